digi_scan_ctrl: RTL and testbench

- Sequences the 4-digit 7-segment display path. Generates the digit-select scan (`ano`) and the refresh timing.
- Arbitrates between two display-value requesters: the CPU `v0` write port and the debug probe.
- Swaps the displayed value only at frame boundaries, so no digit shows mixed old/new data.
- Drives `Digi_decoder` through `disp_value` → `v0` and `ano` → `ano`, plus a per-digit enable for leading-zero blanking.

---
 rtl/digi_pkg.sv | 14 +
 rtl/digi_refresh_timer.sv | 43 ++++
 rtl/digi_scan_ctrl.sv | 133 +++++++++++++
 tb/tb_digi_scan_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/digi_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package digi_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;

    // Display source state: nothing shown yet, CPU value, or debug value.
    typedef enum logic [1:0] {
        BLANK    = 2'd0,
        SHOW_CPU = 2'd1,
        SHOW_DBG = 2'd2
    } state_t;

endpackage

// File: rtl/digi_refresh_timer.sv
// Refresh timing: per-digit divider plus the digit-select scan counter.
// frame_tick marks the last cycle of digit 3, i.e. the last cycle of a frame.
module digi_refresh_timer
    import digi_pkg::*;
#(
    parameter int DIV_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic [DIGIT_W-1:0] ano,
    output logic               digit_tick,
    output logic               frame_tick
);

    localparam int               CNT_W   = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIGIT_W-1:0] ano_q, ano_d;

    // Divider wraps at DIV_CYCLES-1; the scan index advances (and wraps 3->0) on each digit tick.
    always_comb begin
        digit_tick = (div_cnt_q == CNT_MAX);
        frame_tick = digit_tick && (ano_q == LAST_DIGIT);
        div_cnt_d  = digit_tick ? '0 : div_cnt_q + CNT_W'(1);
        ano_d      = digit_tick ? ano_q + DIGIT_W'(1) : ano_q;
    end

    // Divider and scan registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            ano_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ano_q     <= ano_d;
        end
    end

    assign ano = ano_q;

endmodule

// File: rtl/digi_scan_ctrl.sv
// Display sequencer: captures CPU/debug display requests, swaps the shown
// value only at frame boundaries (debug has priority and is held for a
// minimum number of frames), and gates digits for leading-zero blanking.
module digi_scan_ctrl
    import digi_pkg::*;
#(
    parameter int DIV_CYCLES  = 50000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_we,
    input  logic [31:0]        cpu_data,
    input  logic               dbg_req,
    input  logic [31:0]        dbg_data,
    input  logic               lz_en,
    output logic [31:0]        disp_value,
    output logic [DIGIT_W-1:0] ano,
    output logic               seg_en,
    output logic               frame_tick,
    output logic               src_dbg,
    output state_t             dbg_state
);

    localparam int                HOLD_W    = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES - 1);

    state_t              state_q, state_d;
    logic [31:0]         disp_q, disp_d;
    logic [31:0]         cpu_buf_q, cpu_buf_d;
    logic [31:0]         dbg_buf_q, dbg_buf_d;
    logic                cpu_pend_q, cpu_pend_d;
    logic                dbg_pend_q, dbg_pend_d;
    logic                src_dbg_q, src_dbg_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                take_dbg, take_cpu;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                digit_tick_unused;

    // The per-digit strobe is not needed here; only frame boundaries matter.
    digi_refresh_timer #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .ano        (ano),
        .digit_tick (digit_tick_unused),
        .frame_tick (frame_tick)
    );

    // Capture requests every cycle; arbitrate and swap the shown value only on frame_tick,
    // using the buffers as they stood before this edge so a same-cycle write stays pending.
    always_comb begin
        state_d    = state_q;
        disp_d     = disp_q;
        src_dbg_d  = src_dbg_q;
        hold_d     = hold_q;
        cpu_buf_d  = cpu_we  ? cpu_data : cpu_buf_q;
        dbg_buf_d  = dbg_req ? dbg_data : dbg_buf_q;
        cpu_pend_d = cpu_pend_q | cpu_we;
        dbg_pend_d = dbg_pend_q | dbg_req;
        take_dbg   = 1'b0;
        take_cpu   = 1'b0;

        if (frame_tick) begin
            case (state_q)
                BLANK, SHOW_CPU: begin
                    if (dbg_pend_q)      take_dbg = 1'b1;
                    else if (cpu_pend_q) take_cpu = 1'b1;
                end
                SHOW_DBG: begin
                    if (dbg_pend_q)          take_dbg = 1'b1;
                    else if (hold_q != '0)   hold_d   = hold_q - HOLD_W'(1);
                    else if (cpu_pend_q)     take_cpu = 1'b1;
                    else                     state_d  = SHOW_CPU;
                end
                default: state_d = BLANK;
            endcase
        end

        if (take_dbg) begin
            disp_d     = dbg_buf_q;
            src_dbg_d  = 1'b1;
            hold_d     = HOLD_INIT;
            state_d    = SHOW_DBG;
            dbg_pend_d = dbg_req;
        end
        if (take_cpu) begin
            disp_d     = cpu_buf_q;
            src_dbg_d  = 1'b0;
            state_d    = SHOW_CPU;
            cpu_pend_d = cpu_we;
        end
    end

    // Arbitration and display registers; reset drops every pending request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= BLANK;
            disp_q     <= '0;
            cpu_buf_q  <= '0;
            dbg_buf_q  <= '0;
            cpu_pend_q <= 1'b0;
            dbg_pend_q <= 1'b0;
            src_dbg_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            cpu_buf_q  <= cpu_buf_d;
            dbg_buf_q  <= dbg_buf_d;
            cpu_pend_q <= cpu_pend_d;
            dbg_pend_q <= dbg_pend_d;
            src_dbg_q  <= src_dbg_d;
            hold_q     <= hold_d;
        end
    end

    // Leading-zero blanking: digit k lights if blanking is off, it is digit 0,
    // or any nibble at or above it in the low 16 bits is non-zero.
    always_comb begin
        digit_en = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_en[k] = !lz_en || (k == 0) || ((disp_q[15:0] >> (4 * k)) != 16'd0);
        end
        seg_en = (state_q != BLANK) && digit_en[ano];
    end

    assign disp_value = disp_q;
    assign src_dbg    = src_dbg_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_digi_scan_ctrl.sv
// Bench for digi_scan_ctrl with DIV_CYCLES=4, HOLD_FRAMES=2 (16-cycle frames).
// The driver pushes the expected display contents of each frame; a monitor
// checks scan timing every cycle and pops/compares at every frame end.
module tb_digi_scan_ctrl;
  import digi_pkg::*;

  localparam int DIV   = 4;
  localparam int HOLD  = 2;
  localparam int FRAME = 4 * DIV;
  localparam int EXP_W = 37;
  localparam int NONE  = -1;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cpu_we = 1'b0;
  logic [31:0]        cpu_data = '0;
  logic               dbg_req = 1'b0;
  logic [31:0]        dbg_data = '0;
  logic               lz_en = 1'b0;
  logic [31:0]        disp_value;
  logic [DIGIT_W-1:0] ano;
  logic               seg_en;
  logic               frame_tick;
  logic               src_dbg;
  state_t             dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int               n_vec = 0;
  int               n_miss = 0;

  digi_scan_ctrl #(
    .DIV_CYCLES  (DIV),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_we     (cpu_we),
    .cpu_data   (cpu_data),
    .dbg_req    (dbg_req),
    .dbg_data   (dbg_data),
    .lz_en      (lz_en),
    .disp_value (disp_value),
    .ano        (ano),
    .seg_en     (seg_en),
    .frame_tick (frame_tick),
    .src_dbg    (src_dbg),
    .dbg_state  (dbg_state)
  );

  // clock / reset-edge tracking
  always #5 clk = ~clk;

  logic rst_edge_lo = 1'b0;
  always @(posedge clk) rst_edge_lo = !reset_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // monitor / scoreboard
  int               ph = 0;
  int               dig;
  logic [3:0]       mask_acc = '0;
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    if (rst_edge_lo) begin
      chk("rst_disp_value", disp_value, 32'h0);
      chk("rst_ano", 32'(ano), 32'h0);
      chk("rst_seg_en", 32'(seg_en), 32'h0);
      chk("rst_frame_tick", 32'(frame_tick), 32'h0);
      chk("rst_src_dbg", 32'(src_dbg), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'(BLANK));
      mask_acc = '0;
      ph = reset_n ? 1 : 0;
    end else if (reset_n) begin
      dig = (ph / DIV) % 4;
      chk("ano_scan", 32'(ano), 32'(dig));
      chk("frame_tick", 32'(frame_tick), 32'((ph % FRAME) == FRAME - 1));
      mask_acc[dig] = mask_acc[dig] | seg_en;
      if ((ph % FRAME) == FRAME - 1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL frame_pop: got empty queue expected an entry (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("frame_disp_value", disp_value, e[36:5]);
          chk("frame_src_dbg", 32'(src_dbg), 32'(e[4]));
          chk("frame_seg_mask", 32'(mask_acc), 32'(e[3:0]));
        end
        mask_acc = '0;
      end
      ph++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_we  = 1'b0;
    dbg_req = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // One frame: push what should be on display during it, then issue writes at given offsets.
  task automatic run_frame(input logic [31:0] ed, input logic es, input logic [3:0] em,
                           input int c0_off, input logic [31:0] c0_val,
                           input int c1_off, input logic [31:0] c1_val,
                           input int d_off, input logic [31:0] d_val);
    exp_q.push_back({ed, es, em});
    for (int i = 0; i < FRAME; i++) begin
      cpu_we   = (i == c0_off) || (i == c1_off);
      cpu_data = (i == c1_off) ? c1_val : ((i == c0_off) ? c0_val : 32'hDEAD_BEEF);
      dbg_req  = (i == d_off);
      dbg_data = (i == d_off) ? d_val : 32'hBAD0_BAD0;
      step();
    end
    cpu_we  = 1'b0;
    dbg_req = 1'b0;
  endtask

  // stimulus
  initial begin
    do_reset();
    // idle frames: blank display
    for (int f = 0; f < 3; f++)
      run_frame(32'h0, 1'b0, 4'h0, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    // back-to-back CPU writes, last one wins
    run_frame(32'h0, 1'b0, 4'h0, 4, 32'h0000_9999, 5, 32'h0000_1234, NONE, 32'h0);
    // CPU then debug in one frame: debug wins
    run_frame(32'h0000_1234, 1'b0, 4'hF, 2, 32'h0000_AAAA, NONE, 32'h0, 6, 32'h0000_00BE);
    // debug held for HOLD frames, then pending CPU value appears
    run_frame(32'h0000_00BE, 1'b1, 4'hF, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    run_frame(32'h0000_00BE, 1'b1, 4'hF, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    // write on the frame_tick cycle waits one more frame
    run_frame(32'h0000_AAAA, 1'b0, 4'hF, FRAME - 1, 32'h0000_5555, NONE, 32'h0, NONE, 32'h0);
    run_frame(32'h0000_AAAA, 1'b0, 4'hF, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    // leading-zero blanking
    lz_en = 1'b1;
    run_frame(32'h0000_5555, 1'b0, 4'hF, 3, 32'h0000_0007, NONE, 32'h0, NONE, 32'h0);
    run_frame(32'h0000_0007, 1'b0, 4'h1, 4, 32'h0000_0100, NONE, 32'h0, NONE, 32'h0);
    run_frame(32'h0000_0100, 1'b0, 4'h7, 4, 32'h0000_0000, NONE, 32'h0, NONE, 32'h0);
    // simultaneous CPU and debug writes: debug first, CPU left pending
    run_frame(32'h0000_0000, 1'b0, 4'h1, 7, 32'h0000_2222, NONE, 32'h0, 7, 32'h1234_F000);
    run_frame(32'h1234_F000, 1'b1, 4'hF, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    // reset mid-frame while showing debug with CPU pending
    for (int i = 0; i < FRAME / 2; i++) step();
    do_reset();
    run_frame(32'h0, 1'b0, 4'h0, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    run_frame(32'h0, 1'b0, 4'h0, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    // debug request on frame_tick from BLANK
    run_frame(32'h0, 1'b0, 4'h0, NONE, 32'h0, NONE, 32'h0, FRAME - 1, 32'h0000_00BE);
    run_frame(32'h0, 1'b0, 4'h0, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    run_frame(32'h0000_00BE, 1'b1, 4'h3, NONE, 32'h0, NONE, 32'h0, NONE, 32'h0);
    step();
    chk("queue_drain", 32'(exp_q.size()), 32'h0);
    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
